dump_sender: RTL

//  Consumer end of the memory-dump handshake: samples each word presented with i_valid,

---
 rtl/dump_sender_pkg.sv | 22 ++
 rtl/dump_sender_if.sv | 27 ++
 rtl/dump_sender_rise_detect.sv | 19 +
 rtl/dump_sender.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dump_sender_pkg.sv
// Shared types and defaults for the memory-dump sender.
package dump_sender_pkg;

    localparam int unsigned DEF_DATA_SIZE  = 16;
    localparam int unsigned DEF_BYTE_SIZE  = 8;
    localparam int unsigned DEF_END_BYTES  = 2;
    localparam logic [7:0]  DEF_END_MARKER = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA_ST = 3'd1,
        ST_DATA_WT = 3'd2,
        ST_END_ST  = 3'd3,
        ST_END_WT  = 3'd4
    } dump_state_e;

    // Larger of two counts, used to size the shared byte counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dump_sender_if.sv
// Word-in / byte-out handshake bundle between dump address generator, sender and UART TX.
interface dump_sender_if
    import dump_sender_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DEF_DATA_SIZE,
    parameter int unsigned BYTE_SIZE = DEF_BYTE_SIZE
);
    logic                 i_valid;
    logic [DATA_SIZE-1:0] i_data;
    logic                 i_end;
    logic                 i_tx_done;
    logic [BYTE_SIZE-1:0] o_tx_data;
    logic                 o_tx_start;
    logic                 o_ready;
    logic                 o_done;
    logic                 o_overrun;

    modport master (
        output i_valid, i_data, i_end, i_tx_done,
        input  o_tx_data, o_tx_start, o_ready, o_done, o_overrun
    );

    modport slave (
        input  i_valid, i_data, i_end, i_tx_done,
        output o_tx_data, o_tx_start, o_ready, o_done, o_overrun
    );
endinterface

// File: rtl/dump_sender_rise_detect.sv
// Rising-edge detector with a registered history bit of configurable reset value.
module dump_sender_rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_rise_c
);
    logic r_hist;

    // History follows the input every cycle; reset value decides whether a held level is an event.
    always_ff @(posedge i_clock) begin
        if (i_reset) r_hist <= RESET_VAL;
        else         r_hist <= i_sig;
    end

    assign o_rise_c = i_sig & ~r_hist;
endmodule

// File: rtl/dump_sender.sv
// Serialises memory words MSB-byte-first to a UART transmitter and appends an end trailer.
module dump_sender
    import dump_sender_pkg::*;
#(
    parameter int unsigned          DATA_SIZE  = DEF_DATA_SIZE,
    parameter int unsigned          BYTE_SIZE  = DEF_BYTE_SIZE,
    parameter logic [BYTE_SIZE-1:0] END_MARKER = BYTE_SIZE'(DEF_END_MARKER),
    parameter int unsigned          END_BYTES  = DEF_END_BYTES
) (
    input  logic         i_clock,
    input  logic         i_reset,
    dump_sender_if.slave bus
);
    localparam int unsigned NUM_BYTES = DATA_SIZE / BYTE_SIZE;
    localparam int unsigned IDX_W     = $clog2(max_u(NUM_BYTES, END_BYTES)) + 1;

    dump_state_e          r_state, w_next_state;
    logic [DATA_SIZE-1:0] r_shift, w_shift_nxt;
    logic [IDX_W-1:0]     r_byte_idx, w_idx_nxt;
    logic                 r_end_pending, w_end_pending_nxt;
    logic [BYTE_SIZE-1:0] r_tx_data, w_tx_data_nxt;
    logic                 r_tx_start, r_ready, r_done, w_done_nxt;
    logic                 r_overrun, w_overrun_nxt;
    logic                 w_valid_ev, w_end_ev;

    dump_sender_rise_detect #(.RESET_VAL(1'b1)) u_valid_rise (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_sig   (bus.i_valid),
        .o_rise_c(w_valid_ev)
    );

    dump_sender_rise_detect #(.RESET_VAL(1'b1)) u_end_rise (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_sig   (bus.i_end),
        .o_rise_c(w_end_ev)
    );

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state and next-value logic; tx byte is prepared on entry to a *_ST state.
    always_comb begin
        w_next_state      = r_state;
        w_shift_nxt       = r_shift;
        w_idx_nxt         = r_byte_idx;
        w_end_pending_nxt = r_end_pending;
        w_tx_data_nxt     = r_tx_data;
        w_done_nxt        = 1'b0;
        w_overrun_nxt     = r_overrun;

        if (r_state != ST_IDLE) begin
            if (w_valid_ev) w_overrun_nxt     = 1'b1;
            if (w_end_ev)   w_end_pending_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_valid_ev) begin
                    w_shift_nxt   = bus.i_data;
                    w_tx_data_nxt = bus.i_data[DATA_SIZE-1 -: BYTE_SIZE];
                    w_idx_nxt     = '0;
                    w_next_state  = ST_DATA_ST;
                    if (w_end_ev) w_end_pending_nxt = 1'b1;
                end else if (w_end_ev || r_end_pending) begin
                    w_end_pending_nxt = 1'b0;
                    w_tx_data_nxt     = END_MARKER;
                    w_idx_nxt         = '0;
                    w_next_state      = ST_END_ST;
                end
            end
            ST_DATA_ST: w_next_state = ST_DATA_WT;
            ST_DATA_WT: begin
                if (bus.i_tx_done) begin
                    if (r_byte_idx == IDX_W'(NUM_BYTES - 1)) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_shift_nxt   = r_shift << BYTE_SIZE;
                        w_tx_data_nxt = w_shift_nxt[DATA_SIZE-1 -: BYTE_SIZE];
                        w_idx_nxt     = r_byte_idx + IDX_W'(1);
                        w_next_state  = ST_DATA_ST;
                    end
                end
            end
            ST_END_ST: w_next_state = ST_END_WT;
            ST_END_WT: begin
                if (bus.i_tx_done) begin
                    if (r_byte_idx == IDX_W'(END_BYTES - 1)) begin
                        w_done_nxt   = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_idx_nxt    = r_byte_idx + IDX_W'(1);
                        w_next_state = ST_END_ST;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_shift       <= '0;
            r_byte_idx    <= '0;
            r_end_pending <= 1'b0;
            r_tx_data     <= '0;
            r_tx_start    <= 1'b0;
            r_ready       <= 1'b1;
            r_done        <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_shift       <= w_shift_nxt;
            r_byte_idx    <= w_idx_nxt;
            r_end_pending <= w_end_pending_nxt;
            r_tx_data     <= w_tx_data_nxt;
            r_tx_start    <= (w_next_state == ST_DATA_ST) || (w_next_state == ST_END_ST);
            r_ready       <= (w_next_state == ST_IDLE);
            r_done        <= w_done_nxt;
            r_overrun     <= w_overrun_nxt;
        end
    end

    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_tx_start = r_tx_start;
    assign bus.o_ready    = r_ready;
    assign bus.o_done     = r_done;
    assign bus.o_overrun  = r_overrun;
endmodule
